tmr_voter_top: RTL and testbench

- Registered triple-modular-redundancy (TMR) voter. It takes three replicas of a data word and produces their bitwise 2-of-3 majority.
- Also reports which replicas disagree with the voted result and keeps saturating per-replica fault counters.
- Sits at the output of triplicated logic, feeding a single voted word downstream plus fault-monitor status to a supervisor.

---
 rtl/tmr_voter_top.sv | 94 +++++++++
 tb/tb_tmr_voter_top.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_voter_top.sv
// Registered triple-modular-redundancy voter: bitwise 2-of-3 majority of three
// replica words, per-replica disagreement flags and saturating fault counters.
module tmr_voter_top #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] tmr_out,
    output logic             out_valid,
    output logic [2:0]       err_vec,
    output logic             no_word_majority,
    output logic [CNT_W-1:0] err_cnt_1,
    output logic [CNT_W-1:0] err_cnt_2,
    output logic [CNT_W-1:0] err_cnt_3
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] vote_c;
    logic [2:0]       mismatch_c;
    logic             no_majority_c;

    // Bitwise majority and whole-word comparisons, all combinational.
    always_comb begin
        vote_c        = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);
        mismatch_c[0] = (data_1 != vote_c);
        mismatch_c[1] = (data_2 != vote_c);
        mismatch_c[2] = (data_3 != vote_c);
        no_majority_c = (data_1 != data_2) && (data_1 != data_3) && (data_2 != data_3);
    end

    // Voted word and status: captured on valid input, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_out          <= '0;
            out_valid        <= 1'b0;
            err_vec          <= '0;
            no_word_majority <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                tmr_out          <= vote_c;
                err_vec          <= mismatch_c;
                no_word_majority <= no_majority_c;
            end
        end
    end

    logic [CNT_W-1:0] cnt_next_1;
    logic [CNT_W-1:0] cnt_next_2;
    logic [CNT_W-1:0] cnt_next_3;

    // Saturating counter updates; clear wins over a simultaneous fault.
    always_comb begin
        cnt_next_1 = err_cnt_1;
        cnt_next_2 = err_cnt_2;
        cnt_next_3 = err_cnt_3;
        if (cnt_clr) begin
            cnt_next_1 = '0;
            cnt_next_2 = '0;
            cnt_next_3 = '0;
        end else if (in_valid) begin
            if (mismatch_c[0] && (err_cnt_1 != CNT_MAX)) begin
                cnt_next_1 = err_cnt_1 + CNT_ONE;
            end
            if (mismatch_c[1] && (err_cnt_2 != CNT_MAX)) begin
                cnt_next_2 = err_cnt_2 + CNT_ONE;
            end
            if (mismatch_c[2] && (err_cnt_3 != CNT_MAX)) begin
                cnt_next_3 = err_cnt_3 + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_1 <= '0;
            err_cnt_2 <= '0;
            err_cnt_3 <= '0;
        end else begin
            err_cnt_1 <= cnt_next_1;
            err_cnt_2 <= cnt_next_2;
            err_cnt_3 <= cnt_next_3;
        end
    end

endmodule

// File: tb/tb_tmr_voter_top.sv
// Scoreboard bench for tmr_voter_top: directed vectors push expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_tmr_voter_top;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] data_1;
    logic [3:0] data_2;
    logic [3:0] data_3;
    logic       cnt_clr;
    logic [3:0] tmr_out;
    logic       out_valid;
    logic [2:0] err_vec;
    logic       no_word_majority;
    logic [7:0] err_cnt_1;
    logic [7:0] err_cnt_2;
    logic [7:0] err_cnt_3;

    tmr_voter_top #(.WIDTH(4), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .data_1           (data_1),
        .data_2           (data_2),
        .data_3           (data_3),
        .cnt_clr          (cnt_clr),
        .tmr_out          (tmr_out),
        .out_valid        (out_valid),
        .err_vec          (err_vec),
        .no_word_majority (no_word_majority),
        .err_cnt_1        (err_cnt_1),
        .err_cnt_2        (err_cnt_2),
        .err_cnt_3        (err_cnt_3)
    );

    typedef struct packed {
        logic [3:0] tmr;
        logic [2:0] err;
        logic       nwm;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a = '{tmr: tmr_out, err: err_vec, nwm: no_word_majority,
              c1: err_cnt_1, c2: err_cnt_2, c3: err_cnt_3};
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tests++;
                a = actual();
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid: got tmr=%b err=%b with no pending expectation",
                             a.tmr, a.err);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        fails++;
                        $display("FAIL vote_result: got tmr=%b err=%b nwm=%b cnt=%0d/%0d/%0d expected tmr=%b err=%b nwm=%b cnt=%0d/%0d/%0d",
                                 a.tmr, a.err, a.nwm, a.c1, a.c2, a.c3,
                                 e.tmr, e.err, e.nwm, e.c1, e.c2, e.c3);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic clr);
        @(posedge clk);
        #1;
        in_valid = v;
        data_1   = a;
        data_2   = b;
        data_3   = c;
        cnt_clr  = clr;
    endtask

    task automatic vote(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic clr, input logic [3:0] t, input logic [2:0] e,
                        input logic n, input logic [7:0] x1, input logic [7:0] x2,
                        input logic [7:0] x3);
        exp_t ex;
        drive(1'b1, a, b, c, clr);
        ex = '{tmr: t, err: e, nwm: n, c1: x1, c2: x2, c3: x3};
        q.push_back(ex);
    endtask

    logic [7:0] m3;
    exp_t       held;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_1   = '0;
        data_2   = '0;
        data_3   = '0;
        cnt_clr  = 1'b0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            data_1   = 4'($urandom);
            data_2   = 4'($urandom);
            data_3   = 4'($urandom);
        end
        @(negedge clk);
        check("reset_outputs", 64'({actual(), out_valid}), 64'(0));
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Five-vector stream with running counter expectations.
        vote(4'b1011, 4'b1011, 4'b1111, 1'b0, 4'b1011, 3'b100, 1'b0, 8'd0, 8'd0, 8'd1);
        vote(4'b1111, 4'b1001, 4'b1001, 1'b0, 4'b1001, 3'b001, 1'b0, 8'd1, 8'd0, 8'd1);
        vote(4'b1101, 4'b1010, 4'b1101, 1'b0, 4'b1101, 3'b010, 1'b0, 8'd1, 8'd1, 8'd1);
        vote(4'b1010, 4'b1011, 4'b1011, 1'b0, 4'b1011, 3'b001, 1'b0, 8'd2, 8'd1, 8'd1);
        vote(4'b1110, 4'b1011, 4'b1110, 1'b0, 4'b1110, 3'b010, 1'b0, 8'd2, 8'd2, 8'd1);

        // No word majority: bitwise vote matches nobody.
        vote(4'b0001, 4'b0010, 4'b0100, 1'b0, 4'b0000, 3'b111, 1'b1, 8'd3, 8'd3, 8'd2);

        // Hold: new data without in_valid must leave everything unchanged.
        drive(1'b0, 4'b1111, 4'b0000, 4'b0110, 1'b0);
        repeat (3) @(negedge clk);
        held = '{tmr: 4'b0000, err: 3'b111, nwm: 1'b1, c1: 8'd3, c2: 8'd3, c3: 8'd2};
        check("hold_state", 64'(actual()), 64'(held));
        check("hold_out_valid", 64'(out_valid), 64'(0));

        vote(4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0101, 3'b000, 1'b0, 8'd3, 8'd3, 8'd2);

        // Replica 3 faults 300 times in a row; counter 3 must stop at 255.
        m3 = 8'd2;
        for (int k = 0; k < 300; k++) begin
            m3 = (m3 == 8'd255) ? 8'd255 : m3 + 8'd1;
            vote(4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'b100, 1'b0, 8'd3, 8'd3, m3);
        end

        // Clear coincident with a fault wins; counting resumes afterwards.
        vote(4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0000, 3'b100, 1'b0, 8'd0, 8'd0, 8'd0);
        vote(4'b0011, 4'b0111, 4'b0011, 1'b0, 4'b0011, 3'b010, 1'b0, 8'd0, 8'd1, 8'd0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-stream discards the in-flight result.
        drive(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_tmr_out", 64'(tmr_out), 64'(4'b1111));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 64'({actual(), out_valid}), 64'(0));
        repeat (2) @(negedge clk);
        check("reset_out_valid_low", 64'(out_valid), 64'(0));
        in_valid = 1'b0;
        rst_n    = 1'b1;

        vote(4'b0110, 4'b0110, 4'b0111, 1'b0, 4'b0110, 3'b100, 1'b0, 8'd0, 8'd0, 8'd1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
